// File: rtl/cdb_arbiter.sv
// Two-source CDB arbiter: private FIFO per source, round-robin on tie, one broadcast per cycle.
// Latency 1 cycle accept->cdb_valid; x_ready drops while full, rdy low, flush or rst.
module cdb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= wrap_inc(tail);
            if (pop)  head <= wrap_inc(head);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset; the count alone says what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_dat;
    end

    assign head_dat = mem[head];
endmodule

module cdb_arbiter #(
    parameter int ROB_IDX_W  = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 alu_valid,
    input  logic [ROB_IDX_W-1:0] alu_idx,
    input  logic [DATA_W-1:0]    alu_val,
    output logic                 alu_ready,
    input  logic                 lsb_valid,
    input  logic [ROB_IDX_W-1:0] lsb_idx,
    input  logic [DATA_W-1:0]    lsb_val,
    output logic                 lsb_ready,
    output logic                 cdb_valid,
    output logic [ROB_IDX_W-1:0] cdb_idx,
    output logic [DATA_W-1:0]    cdb_val,
    output logic                 cdb_src
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ROB_IDX_W-1:0] idx;
        logic [DATA_W-1:0]    val;
    } cdb_ent_t;

    cdb_ent_t         alu_ent, lsb_ent, alu_head, lsb_head, win_ent;
    logic [CNT_W-1:0] alu_cnt, lsb_cnt;
    logic             alu_push, lsb_push, alu_pop, lsb_pop;
    logic             alu_ne, lsb_ne, pop_any, grant_lsb;
    logic             last_lsb;
    logic             run;

    assign alu_ent = '{idx: alu_idx, val: alu_val};
    assign lsb_ent = '{idx: lsb_idx, val: lsb_val};

    assign run       = rdy && !rst && !flush;
    // Ready ignores a same-cycle pop: a full FIFO never takes a new entry.
    assign alu_ready = run && (alu_cnt < CNT_W'(FIFO_DEPTH));
    assign lsb_ready = run && (lsb_cnt < CNT_W'(FIFO_DEPTH));
    assign alu_push  = alu_valid && alu_ready;
    assign lsb_push  = lsb_valid && lsb_ready;

    assign alu_ne    = (alu_cnt != '0);
    assign lsb_ne    = (lsb_cnt != '0);
    assign pop_any   = run && (alu_ne || lsb_ne);
    // On a tie the source that did not win last time goes next.
    assign grant_lsb = lsb_ne && (!alu_ne || !last_lsb);
    assign alu_pop   = pop_any && !grant_lsb;
    assign lsb_pop   = pop_any && grant_lsb;
    assign win_ent   = grant_lsb ? lsb_head : alu_head;

    cdb_fifo #(.W(ROB_IDX_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push     (alu_push),
        .push_dat (alu_ent),
        .pop      (alu_pop),
        .head_dat (alu_head),
        .count    (alu_cnt)
    );

    cdb_fifo #(.W(ROB_IDX_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push     (lsb_push),
        .push_dat (lsb_ent),
        .pop      (lsb_pop),
        .head_dat (lsb_head),
        .count    (lsb_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_idx   <= '0;
            cdb_val   <= '0;
            cdb_src   <= 1'b0;
            last_lsb  <= 1'b1;
        end else if (flush) begin
            cdb_valid <= 1'b0;
            last_lsb  <= 1'b1;
        end else begin
            cdb_valid <= pop_any;
            if (pop_any) begin
                cdb_idx  <= win_ent.idx;
                cdb_val  <= win_ent.val;
                cdb_src  <= grant_lsb;
                last_lsb <= grant_lsb;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, streaming sequence, and randomized run against a queue model.
module tb_cdb_arbiter;
    localparam int IW = 4;
    localparam int DW = 32;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1, rdy = 1'b0, flush = 1'b0;
    logic          alu_valid = 1'b0, lsb_valid = 1'b0;
    logic [IW-1:0] alu_idx = '0, lsb_idx = '0;
    logic [DW-1:0] alu_val = '0, lsb_val = '0;
    logic          alu_ready, lsb_ready, cdb_valid, cdb_src;
    logic [IW-1:0] cdb_idx;
    logic [DW-1:0] cdb_val;

    always #5 clk = ~clk;

    cdb_arbiter #(.ROB_IDX_W(IW), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .alu_valid (alu_valid),
        .alu_idx   (alu_idx),
        .alu_val   (alu_val),
        .alu_ready (alu_ready),
        .lsb_valid (lsb_valid),
        .lsb_idx   (lsb_idx),
        .lsb_val   (lsb_val),
        .lsb_ready (lsb_ready),
        .cdb_valid (cdb_valid),
        .cdb_idx   (cdb_idx),
        .cdb_val   (cdb_val),
        .cdb_src   (cdb_src)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: one queue per source plus who won the last tie.
    logic [IW+DW-1:0] mq_a[$];
    logic [IW+DW-1:0] mq_l[$];
    bit               m_last_lsb = 1'b1;
    logic             m_v = 1'b0, m_s = 1'b0;
    logic [IW-1:0]    m_i = '0;
    logic [DW-1:0]    m_d = '0;

    function automatic bit exp_ready(input int size);
        return rdy && !rst && !flush && (size < D);
    endfunction

    // Called just after a rising edge, while the pre-edge inputs are still applied.
    task automatic model_edge(output bit acc_a, output bit acc_l);
        logic [IW+DW-1:0] e;
        bit take_l;
        acc_a = exp_ready(mq_a.size()) && alu_valid;
        acc_l = exp_ready(mq_l.size()) && lsb_valid;
        if (rst) begin
            mq_a.delete(); mq_l.delete();
            m_v = 0; m_i = '0; m_d = '0; m_s = 0; m_last_lsb = 1;
        end else if (flush) begin
            mq_a.delete(); mq_l.delete();
            m_v = 0; m_last_lsb = 1;
        end else if (!rdy) begin
            m_v = 0;
        end else begin
            if (mq_a.size() > 0 || mq_l.size() > 0) begin
                take_l = (mq_l.size() > 0) && (mq_a.size() == 0 || !m_last_lsb);
                e = take_l ? mq_l.pop_front() : mq_a.pop_front();
                m_v = 1; m_s = take_l; m_i = e[IW+DW-1:DW]; m_d = e[DW-1:0];
                m_last_lsb = take_l;
            end else begin
                m_v = 0;
            end
            if (acc_a) mq_a.push_back({alu_idx, alu_val});
            if (acc_l) mq_l.push_back({lsb_idx, lsb_val});
        end
    endtask

    task automatic step(input string tag, output bit acc_a, output bit acc_l);
        #1;
        chk({tag, " alu_ready"}, alu_ready, exp_ready(mq_a.size()));
        chk({tag, " lsb_ready"}, lsb_ready, exp_ready(mq_l.size()));
        @(posedge clk);
        model_edge(acc_a, acc_l);
        #1;
        chk({tag, " cdb_valid"}, cdb_valid, m_v);
        chk({tag, " cdb_idx"}, cdb_idx, m_i);
        chk({tag, " cdb_val"}, cdb_val, m_d);
        chk({tag, " cdb_src"}, cdb_src, m_s);
    endtask

    typedef struct {
        logic          rst, rdy, flush, av;
        logic [IW-1:0] ai;
        logic [DW-1:0] ad;
        logic          lv;
        logic [IW-1:0] li;
        logic [DW-1:0] ld;
        logic          er_a, er_l, ev;
        logic [IW-1:0] ei;
        logic [DW-1:0] ed;
        logic          es;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic y, input logic f,
                                input logic av, input logic [IW-1:0] ai, input logic [DW-1:0] ad,
                                input logic lv, input logic [IW-1:0] li, input logic [DW-1:0] ld,
                                input logic ea, input logic el, input logic ev,
                                input logic [IW-1:0] ei, input logic [DW-1:0] ed, input logic es);
        vec_t v;
        v.rst = r; v.rdy = y; v.flush = f;
        v.av = av; v.ai = ai; v.ad = ad; v.lv = lv; v.li = li; v.ld = ld;
        v.er_a = ea; v.er_l = el; v.ev = ev; v.ei = ei; v.ed = ed; v.es = es;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        bit acc_a, acc_l, prev_v, prev_s;
        int seq;
        // rst rdy fl | av ai ad | lv li ld | ready a/l | valid idx val src
        tbl.push_back(mk(1,1,0, 0,0,0,       0,0,0,       0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 1,3,'h55,    0,0,0,       1,1, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0,       0,0,0,       1,1, 1,3,'h55,0));
        tbl.push_back(mk(0,1,0, 0,0,0,       0,0,0,       1,1, 0,3,'h55,0));
        tbl.push_back(mk(1,1,0, 0,0,0,       0,0,0,       0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 1,1,'h11,    1,2,'h22,    1,1, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0,       0,0,0,       1,1, 1,1,'h11,0));
        tbl.push_back(mk(0,1,0, 0,0,0,       0,0,0,       1,1, 1,2,'h22,1));
        tbl.push_back(mk(0,1,0, 0,0,0,       0,0,0,       1,1, 0,2,'h22,1));
        tbl.push_back(mk(0,1,0, 0,0,0,       1,5,'h50,    1,1, 0,2,'h22,1));
        tbl.push_back(mk(0,0,0, 1,6,'h60,    0,0,0,       0,0, 0,2,'h22,1));
        tbl.push_back(mk(0,0,0, 1,6,'h60,    0,0,0,       0,0, 0,2,'h22,1));
        tbl.push_back(mk(0,0,0, 1,6,'h60,    0,0,0,       0,0, 0,2,'h22,1));
        tbl.push_back(mk(0,1,0, 1,6,'h60,    0,0,0,       1,1, 1,5,'h50,1));
        tbl.push_back(mk(0,1,0, 1,7,'h70,    0,0,0,       1,1, 1,6,'h60,0));
        tbl.push_back(mk(0,1,0, 1,8,'h80,    0,0,0,       1,1, 1,7,'h70,0));
        tbl.push_back(mk(0,1,0, 0,0,0,       0,0,0,       1,1, 1,8,'h80,0));
        tbl.push_back(mk(0,1,0, 0,0,0,       0,0,0,       1,1, 0,8,'h80,0));
        tbl.push_back(mk(0,1,0, 1,9,'h90,    1,10,'hA0,   1,1, 0,8,'h80,0));
        tbl.push_back(mk(0,1,0, 1,11,'hB0,   1,12,'hC0,   1,1, 1,10,'hA0,1));
        tbl.push_back(mk(0,1,1, 1,13,'hD0,   1,14,'hE0,   0,0, 0,10,'hA0,1));
        tbl.push_back(mk(0,1,0, 0,0,0,       0,0,0,       1,1, 0,10,'hA0,1));
        tbl.push_back(mk(0,1,0, 0,0,0,       0,0,0,       1,1, 0,10,'hA0,1));
        tbl.push_back(mk(0,1,0, 1,1,'h101,   1,2,'h202,   1,1, 0,10,'hA0,1));
        tbl.push_back(mk(1,1,0, 1,3,'h303,   1,4,'h404,   0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0,       0,0,0,       1,1, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 1,4,'h4,     1,5,'h5,     1,1, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0,       0,0,0,       1,1, 1,4,'h4,0));
        tbl.push_back(mk(0,1,0, 0,0,0,       0,0,0,       1,1, 1,5,'h5,1));

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            rst = tbl[i].rst; rdy = tbl[i].rdy; flush = tbl[i].flush;
            alu_valid = tbl[i].av; alu_idx = tbl[i].ai; alu_val = tbl[i].ad;
            lsb_valid = tbl[i].lv; lsb_idx = tbl[i].li; lsb_val = tbl[i].ld;
            #1;
            chk($sformatf("row%0d alu_ready", i), alu_ready, tbl[i].er_a);
            chk($sformatf("row%0d lsb_ready", i), lsb_ready, tbl[i].er_l);
            @(posedge clk);
            model_edge(acc_a, acc_l);
            #1;
            chk($sformatf("row%0d cdb_valid", i), cdb_valid, tbl[i].ev);
            chk($sformatf("row%0d cdb_idx", i), cdb_idx, tbl[i].ei);
            chk($sformatf("row%0d cdb_val", i), cdb_val, tbl[i].ed);
            chk($sformatf("row%0d cdb_src", i), cdb_src, tbl[i].es);
        end

        // Both sources stream continuously: once flowing, grants must alternate every cycle.
        rst = 0; rdy = 1; flush = 0;
        alu_valid = 1; lsb_valid = 1;
        alu_idx = 0; alu_val = 'h1000; lsb_idx = 8; lsb_val = 'h2000;
        prev_v = 0; prev_s = 0;
        for (int c = 0; c < 16; c++) begin
            step("stream", acc_a, acc_l);
            if (cdb_valid && prev_v) chk("stream alternate", cdb_src, !prev_s);
            prev_v = cdb_valid; prev_s = cdb_src;
            if (acc_a) begin alu_idx = alu_idx + 1'b1; alu_val = alu_val + 1; end
            if (acc_l) begin lsb_idx = lsb_idx + 1'b1; lsb_val = lsb_val + 1; end
        end
        alu_valid = 0; lsb_valid = 0;
        for (int c = 0; c < 4; c++) step("drain", acc_a, acc_l);

        // Randomized traffic; an unaccepted offer keeps its data until taken.
        seq = 0;
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(63) == 0);
            flush = ($urandom_range(15) == 0);
            rdy   = ($urandom_range(3) != 0);
            step("rand", acc_a, acc_l);
            if (!alu_valid || acc_a) begin
                alu_valid = $urandom_range(1);
                alu_idx   = IW'($urandom);
                alu_val   = DW'(seq++);
            end
            if (!lsb_valid || acc_l) begin
                lsb_valid = $urandom_range(1);
                lsb_idx   = IW'($urandom);
                lsb_val   = DW'(seq++) | 32'h8000_0000;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter ROB_IDX_W, default 4, ROB entry index width.
REQ-002 Parameter DATA_W, default 32, result value width.
REQ-003 Parameter FIFO_DEPTH, default 2, entries per source FIFO.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 rdy  input  1  global enable; low stalls the block.
REQ-007 flush  input  1  mispredict flush (ROB jp_wrong).
REQ-008 alu_valid  input  1  RS/ALU result offered.
REQ-009 alu_idx  input  ROB_IDX_W  ROB entry of ALU result.
REQ-010 alu_val  input  DATA_W  ALU result value.
REQ-011 alu_ready  output  1  ALU FIFO can accept this cycle.
REQ-012 lsb_valid  input  1  LSB load result offered.
REQ-013 lsb_idx  input  ROB_IDX_W  ROB entry of LSB result.
REQ-014 lsb_val  input  DATA_W  LSB result value.
REQ-015 lsb_ready  output  1  LSB FIFO can accept this cycle.
REQ-016 cdb_valid  output  1  broadcast valid (registered).
REQ-017 cdb_idx  output  ROB_IDX_W  broadcast ROB entry.
REQ-018 cdb_val  output  DATA_W  broadcast value.
REQ-019 cdb_src  output  1  granted source: 0 = ALU, 1 = LSB.

Function
REQ-020 Each source SHALL have a private FIFO of FIFO_DEPTH {idx, val} entries, with head and tail pointers wrapping modulo FIFO_DEPTH and a count of 0..FIFO_DEPTH.
REQ-021 x_ready SHALL be combinational: rdy && !rst && !flush && count_x < FIFO_DEPTH; a full FIFO SHALL NOT accept, even in a cycle where it pops.
REQ-022 A push SHALL occur on a rising edge where x_valid && x_ready; x_valid without x_ready SHALL be ignored, and the source SHALL hold its data.
REQ-023 At most one entry SHALL pop per cycle, and only when rdy is high and at least one FIFO is non-empty.
REQ-024 If exactly one FIFO is non-empty, that FIFO SHALL be granted.
REQ-025 If both FIFOs are non-empty, the source not granted last SHALL be granted (round-robin); the last_grant register SHALL update on every grant.
REQ-026 The popped head SHALL appear on cdb_idx/cdb_val/cdb_src with cdb_valid=1 on the edge of the pop; minimum latency from accept edge to cdb_valid is 1 cycle.
REQ-027 A cycle with no pop SHALL drive cdb_valid=0 on the next edge; cdb_idx/cdb_val SHALL hold their prior values.
REQ-028 An entry pushed on edge N SHALL NOT be popped before edge N+1; there is no bypass from input to the CDB.
REQ-029 A simultaneous push and pop on the same FIFO SHALL leave its count unchanged.
REQ-030 Entries from one source SHALL be broadcast in arrival order; no entry SHALL be dropped or duplicated.
REQ-031 While rdy=0, FIFO contents, pointers, counts and last_grant SHALL hold, and cdb_valid SHALL be 0 from the next edge.
REQ-032 A flush edge SHALL empty both FIFOs, clear cdb_valid and set last_grant so the ALU wins the next tie; pushes offered in the flush cycle SHALL be discarded.
REQ-033 Precedence SHALL be: rst over flush over rdy=0 over normal operation.

Reset
REQ-034 On a rst edge: both counts and all pointers 0, cdb_valid=0, cdb_idx=0, cdb_val=0, cdb_src=0, last_grant set so the ALU wins the first tie.
REQ-035 While rst is high, alu_ready and lsb_ready SHALL be 0.

Verification
REQ-036 Single ALU push idx=3, val=0x55 -> next edge: cdb_valid=1, cdb_idx=3, cdb_val=0x55, cdb_src=0; following edge: cdb_valid=0.
REQ-037 ALU and LSB push in the same cycle (idx 1, idx 2), after reset -> idx 1 (src 0) then idx 2 (src 1) on consecutive cycles.
REQ-038 Both sources stream continuously with the FIFOs kept full -> grants alternate ALU/LSB every cycle; x_ready is low whenever count=2.
REQ-039 Three ALU pushes while the LSB holds one entry and rdy=0 -> alu_ready=0, no broadcast; after rdy=1, order is preserved and nothing is lost.
REQ-040 Flush asserted with 2 entries queued per source plus a push offered -> next edge: cdb_valid=0, both ready=1, and no stale idx is ever broadcast.
REQ-041 rst asserted mid-stream with the FIFOs half full -> all REQ-034 values hold on the next edge.
